// File: rtl/amba3_axi_mem_slave.sv
// AMBA 3 AXI slave over an on-chip word memory with byte-strobed writes.
// One outstanding write and one outstanding read; the two paths run independently.
module amba3_axi_mem_slave #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128,
  parameter int MEM_WORDS = 256
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [TXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [TXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [TXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [TXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);
  localparam int STRB  = DATA_SIZE / 8;
  localparam int ALSB  = $clog2(STRB);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DATA_SIZE-1:0] mem [MEM_WORDS];

  // Address of the beat following a, for FIXED/INCR/WRAP; illegal WRAP lengths and type 11 act as INCR.
  function automatic logic [ADDR_SIZE-1:0] next_addr(
    input logic [ADDR_SIZE-1:0] a, input logic [2:0] sz,
    input logic [3:0] ln, input logic [1:0] bt);
    logic [ADDR_SIZE-1:0] incr, wmask;
    logic                 wrap_ok;
    incr    = ADDR_SIZE'(1) << sz;
    wmask   = (({{(ADDR_SIZE-4){1'b0}}, ln} + ADDR_SIZE'(1)) << sz) - ADDR_SIZE'(1);
    wrap_ok = (ln == 4'd1) || (ln == 4'd3) || (ln == 4'd7) || (ln == 4'd15);
    if (bt == 2'b00)
      return a;
    else if (bt == 2'b10 && wrap_ok)
      return (a & ~wmask) | ((a + incr) & wmask);
    else
      return a + incr;
  endfunction

  wstate_t              wstate;
  logic [TXID_SIZE-1:0] wid_q;
  logic [ADDR_SIZE-1:0] waddr;
  logic [3:0]           wlen, wcnt;
  logic [2:0]           wsize;
  logic [1:0]           wburst;
  logic                 werr;
  logic                 w_hs, w_err_now;

  assign w_hs      = wvalid && wready;
  assign w_err_now = werr || (wlast != (wcnt == wlen));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= 2'b00;
      wid_q   <= '0;
      waddr   <= '0;
      wlen    <= '0;
      wsize   <= '0;
      wburst  <= '0;
      wcnt    <= '0;
      werr    <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            wid_q   <= awid;
            waddr   <= awaddr;
            wlen    <= awlen;
            wsize   <= awsize;
            wburst  <= awburst;
            wcnt    <= '0;
            werr    <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b1;
            wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            werr <= w_err_now;
            // The counter, not wlast, decides where the burst ends.
            if (wcnt == wlen) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= wid_q;
              bresp  <= w_err_now ? 2'b10 : 2'b00;
              wstate <= W_RESP;
            end else begin
              wcnt  <= wcnt + 4'd1;
              waddr <= next_addr(waddr, wsize, wlen, wburst);
            end
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int i = 0; i < STRB; i++)
        if (wstrb[i]) mem[waddr[ALSB +: IDX_W]][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  rstate_t              rstate;
  logic [ADDR_SIZE-1:0] raddr;
  logic [3:0]           rlen, rcnt;
  logic [2:0]           rsize;
  logic [1:0]           rburst;

  assign rresp = 2'b00;

  // raddr always holds the address of the next beat to load, so rdata is a plain registered read.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      raddr   <= '0;
      rlen    <= '0;
      rsize   <= '0;
      rburst  <= '0;
      rcnt    <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            rid     <= arid;
            rlen    <= arlen;
            rsize   <= arsize;
            rburst  <= arburst;
            rcnt    <= '0;
            rdata   <= mem[araddr[ALSB +: IDX_W]];
            raddr   <= next_addr(araddr, arsize, arlen, arburst);
            rlast   <= (arlen == 4'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              rstate  <= R_IDLE;
            end else begin
              rdata <= mem[raddr[ALSB +: IDX_W]];
              raddr <= next_addr(raddr, rsize, rlen, rburst);
              rcnt  <= rcnt + 4'd1;
              rlast <= ((rcnt + 4'd1) == rlen);
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  logic unused_sig;
  assign unused_sig = ^wid;
endmodule

// File: tb/tb_amba3_axi_mem_slave.sv
// Bench for amba3_axi_mem_slave: directed and randomized bursts checked against a
// behavioural word-memory model; a negedge monitor compares B and R traffic every cycle.
module tb_amba3_axi_mem_slave;
  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   awid, wid, bid, arid, rid;
  logic [31:0]  awaddr, araddr;
  logic [3:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  amba3_axi_mem_slave dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [3:0] id; logic [127:0] data; logic last; } rbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bresp_t;

  logic [127:0] mm [256];
  logic [127:0] wdat [16];
  logic [15:0]  wstb [16];
  rbeat_t       exp_r[$];
  bresp_t       exp_b[$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 4) & 32'hFF);
  endfunction

  // Closed-form beat address: beat i of a burst.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] incr, window, base;
    incr = 32'd1 << size;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      window = (32'(len) + 1) * incr;
      base   = (a / window) * window;
      return base + ((a - base) + 32'(i) * incr) % window;
    end
    return a + 32'(i) * incr;
  endfunction

  task automatic wait_rdy(input int which, output bit ok);
    bit r;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      case (which)
        0:       r = awready;
        1:       r = wready;
        default: r = arready;
      endcase
      @(posedge aclk);
      if (r) begin ok = 1'b1; break; end
    end
    #1;
    if (!ok) begin
      miscompares++;
      $display("FAIL handshake_timeout ch%0d: got no ready, expected ready within 200 cycles", which);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bad,
                          output logic [1:0] resp);
    bit ok, err;
    bit lst [16];
    int w, st, cyc;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w = word_of(beat_addr(addr, len, size, burst, i));
      for (int b = 0; b < 16; b++)
        if (wstb[i][b]) mm[w][b*8 +: 8] = wdat[i][b*8 +: 8];
      lst[i] = (bad >= 0) ? (i == bad) : (i == int'(len));
      if (lst[i] != (i == int'(len))) err = 1'b1;
    end
    resp = err ? 2'b10 : 2'b00;
    exp_b.push_back('{id, resp});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_rdy(0, ok);
    awvalid = 1'b0;
    @(negedge aclk);
    chk("wready_after_aw", 128'(wready), 128'd1);
    @(posedge aclk); #1;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
      wvalid = 1'b1; wdata = wdat[i]; wstrb = wstb[i]; wlast = lst[i]; wid = 4'($urandom);
      wait_rdy(1, ok);
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    chk("bvalid_after_last_w", 128'(bvalid), 128'd1);
    st = $urandom_range(0, 10);
    @(posedge aclk); #1;
    for (int k = 0; k < st; k++) begin @(posedge aclk); #1; end
    bready = 1'b1;
    cyc = 0;
    while (exp_b.size() > 0 && cyc < 50) begin @(posedge aclk); #1; cyc++; end
    if (exp_b.size() > 0) begin
      miscompares++;
      $display("FAIL b_timeout: got no B handshake, expected one within 50 cycles");
      exp_b.delete();
    end
    bready = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    rbeat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id;
      b.data = mm[word_of(beat_addr(addr, len, size, burst, i))];
      b.last = (i == int'(len));
      exp_r.push_back(b);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit stall);
    bit ok;
    int cyc, st;
    push_read(id, addr, len, size, burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    rready = !stall;
    wait_rdy(2, ok);
    arvalid = 1'b0;
    @(negedge aclk);
    chk("rvalid_after_ar", 128'(rvalid), 128'd1);
    cyc = 0; st = 0;
    while (exp_r.size() > 0 && cyc < 400) begin
      @(posedge aclk); #1; cyc++;
      if (stall) begin
        if (st > 0) begin rready = 1'b0; st--; end
        else begin
          rready = 1'b1;
          if ($urandom_range(0, 2) == 0) st = $urandom_range(1, 10);
        end
      end
    end
    if (exp_r.size() > 0) begin
      miscompares++;
      $display("FAIL r_timeout: got %0d beats outstanding, expected 0", exp_r.size());
      exp_r.delete();
    end else if (!stall) begin
      chk("read_burst_cycles", 128'(cyc), 128'(int'(len) + 1));
    end
    rready = 1'b0;
  endtask

  // Monitor: every cycle outside reset, check handshakes against the model queues and
  // that a valid held against a low ready keeps its payload.
  logic         prev_rv, prev_rr, prev_bv, prev_br;
  logic [127:0] prev_rdata;
  logic [6:0]   prev_rctl;
  logic [5:0]   prev_bctl;
  always @(negedge aclk) begin
    if (areset) begin
      prev_rv = 1'b0; prev_rr = 1'b0; prev_bv = 1'b0; prev_br = 1'b0;
    end else begin
      if (awready && wready) chk("aw_w_same_cycle", 128'd1, 128'd0);
      if (prev_rv && !prev_rr) begin
        chk("rvalid_held", 128'(rvalid), 128'd1);
        chk("rdata_stable", rdata, prev_rdata);
        chk("r_ctl_stable", 128'({rid, rlast, rresp}), 128'(prev_rctl));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("unexpected_r_beat", 128'd1, 128'd0);
        else begin
          rbeat_t e;
          e = exp_r.pop_front();
          chk("rdata", rdata, e.data);
          chk("rid", 128'(rid), 128'(e.id));
          chk("rlast", 128'(rlast), 128'(e.last));
          chk("rresp", 128'(rresp), 128'd0);
        end
      end
      if (prev_bv && !prev_br) begin
        chk("bvalid_held", 128'(bvalid), 128'd1);
        chk("b_stable", 128'({bid, bresp}), 128'(prev_bctl));
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("unexpected_b", 128'd1, 128'd0);
        else begin
          bresp_t e;
          e = exp_b.pop_front();
          chk("bid", 128'(bid), 128'(e.id));
          chk("bresp", 128'(bresp), 128'(e.resp));
        end
      end
      prev_rv = rvalid; prev_rr = rready; prev_rdata = rdata; prev_rctl = {rid, rlast, rresp};
      prev_bv = bvalid; prev_br = bready; prev_bctl = {bid, bresp};
    end
  end

  initial begin
    logic [1:0]  resp;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [3:0]  ln;
    logic [1:0]  bt;
    int          bad;
    bit          ok;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awready", 128'(awready), 128'd0);
    chk("rst_arready", 128'(arready), 128'd0);
    chk("rst_outputs", 128'({wready, bvalid, rvalid, rlast, bresp, bid, rid}), 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("awready_before_edge", 128'(awready), 128'd0);
    @(negedge aclk);
    chk("awready_after_edge", 128'(awready), 128'd1);
    chk("arready_after_edge", 128'(arready), 128'd1);
    @(posedge aclk); #1;

    // Fill the whole memory so every later read has a known model value.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) begin
        wdat[i] = {$urandom, $urandom, $urandom, $urandom}; wstb[i] = 16'hFFFF;
      end
      do_write(4'(k), 32'(k * 256), 4'd15, 3'd4, 2'b01, -1, resp);
    end

    for (int i = 0; i < 4; i++) begin wdat[i] = 128'(8'h11 + i); wstb[i] = 16'hFFFF; end
    do_write(4'h3, 32'h100, 4'd3, 3'd4, 2'b01, -1, resp);
    chk("pin_incr_resp", 128'(resp), 128'd0);
    chk("pin_incr_word", mm[16'h13], 128'h14);
    do_read(4'h5, 32'h100, 4'd3, 3'd4, 2'b01, 1'b0);

    do_write(4'h1, 32'h10, 4'd3, 3'd4, 2'b00, -1, resp);
    chk("pin_fixed_word", mm[1], 128'h14);
    do_read(4'h2, 32'h10, 4'd0, 3'd4, 2'b01, 1'b0);

    wdat[0] = '1; wstb[0] = 16'hFFFF;
    do_write(4'h4, 32'h200, 4'd0, 3'd4, 2'b01, -1, resp);
    wdat[0] = 128'hAB; wstb[0] = 16'h0001;
    do_write(4'h4, 32'h200, 4'd0, 3'd4, 2'b01, -1, resp);
    chk("pin_strobe_word", mm[32], {{15{8'hFF}}, 8'hAB});
    do_read(4'h6, 32'h200, 4'd0, 3'd4, 2'b01, 1'b0);

    for (int i = 0; i < 4; i++) begin wdat[i] = 128'(8'hA0 + i); wstb[i] = 16'hFFFF; end
    do_write(4'h7, 32'h100, 4'd3, 3'd4, 2'b01, -1, resp);
    chk("pin_wrap_b0", mm[word_of(beat_addr(32'h130, 4'd3, 3'd4, 2'b10, 0))], 128'hA3);
    chk("pin_wrap_b1", mm[word_of(beat_addr(32'h130, 4'd3, 3'd4, 2'b10, 1))], 128'hA0);
    chk("pin_wrap_b3", mm[word_of(beat_addr(32'h130, 4'd3, 3'd4, 2'b10, 3))], 128'hA2);
    do_read(4'h8, 32'h130, 4'd3, 3'd4, 2'b10, 1'b1);

    for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom, $urandom, $urandom}; wstb[i] = 16'hFFFF; end
    do_write(4'h9, 32'h300, 4'd3, 3'd4, 2'b01, 1, resp);
    chk("pin_early_wlast_resp", 128'(resp), 128'h2);
    do_read(4'hA, 32'h300, 4'd3, 3'd4, 2'b01, 1'b1);

    for (int t = 0; t < 60; t++) begin
      sz = 3'($urandom_range(0, 4));
      a  = 32'($urandom_range(0, 32'h3FFF)) & ~((32'd1 << sz) - 32'd1);
      ln = 4'($urandom_range(0, 15));
      bt = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = {$urandom, $urandom, $urandom, $urandom}; wstb[i] = 16'($urandom);
        end
        bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(ln))) : -1;
        do_write(4'($urandom), a, ln, sz, bt, bad, resp);
      end else begin
        do_read(4'($urandom), a, ln, sz, bt, 1'b1);
      end
    end

    // Abort a read mid-burst with reset; memory must survive.
    push_read(4'hC, 32'h0, 4'd15, 3'd4, 2'b01);
    arid = 4'hC; araddr = 32'h0; arlen = 4'd15; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b1;
    wait_rdy(2, ok);
    arvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_rvalid", 128'(rvalid), 128'd0);
    chk("mid_rst_ready", 128'({arready, awready, wready, bvalid, rlast}), 128'd0);
    exp_r.delete();
    rready = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("arready_before_edge", 128'(arready), 128'd0);
    @(negedge aclk);
    chk("arready_after_release", 128'(arready), 128'd1);
    @(posedge aclk); #1;
    do_read(4'hD, 32'h100, 4'd3, 3'd4, 2'b01, 1'b0);

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/amba3_axi_mem_slave.md
# amba3_axi_mem_slave

Synthesizable AMBA 3 AXI slave backed by an on-chip word memory. It accepts write bursts and stores the data with byte strobes, then returns the stored data on read bursts. It is the endpoint for the AXI master bus-functional model in the AMBA 3 verification environment and serves as a generic scratch-memory target. It has one outstanding write and one outstanding read, and the two paths run independently.

## Interface
- TXID_SIZE, 4, ID width of all channels.
- ADDR_SIZE, 32, byte-address width.
- DATA_SIZE, 128, data width in bits; legal values are 32, 64 and 128.
- MEM_WORDS, 256, memory depth in DATA_SIZE words; must be a power of two.

Ports:
- aclk  in  1  clock; all logic samples on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- awid/awaddr/awlen/awsize/awburst  in  TXID_SIZE/ADDR_SIZE/4/3/2  write address fields.
- awvalid in 1, awready out 1  write address handshake.
- wid/wdata/wstrb/wlast  in  TXID_SIZE/DATA_SIZE/DATA_SIZE/8/1  write data fields; wid is ignored.
- wvalid in 1, wready out 1  write data handshake.
- bid/bresp  out  TXID_SIZE/2  write response fields.
- bvalid out 1, bready in 1  write response handshake.
- arid/araddr/arlen/arsize/arburst  in  same widths as the AW channel  read address fields.
- arvalid in 1, arready out 1  read address handshake.
- rid/rdata/rresp/rlast  out  TXID_SIZE/DATA_SIZE/2/1  read data fields.
- rvalid out 1, rready in 1  read data handshake.

## Operation
- Word index = (addr >> log2(DATA_SIZE/8)) mod MEM_WORDS. Addresses alias beyond the memory size. Memory contents are not reset.
- Beat address for each burst type:
  - FIXED (00): constant address.
  - INCR (01): address += 2^size after each beat.
  - WRAP (10): INCR, wrapping within an aligned window of (len+1)*2^size bytes. WRAP is legal only for len = 1, 3, 7 or 15; any other len is treated as INCR.
  - Burst type 11 is treated as INCR.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, address, len, size and burst, clear the beat counter and error flag, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes of wdata whose wstrb bit is 1 into the addressed word, then advances the address and counter.
  - If wlast differs from (counter==len) on any beat, the error flag is set.
  - The beat with counter==len ends the burst and goes to W_RESP. The counter governs the burst length; wlast does not.
  - W_RESP: bvalid=1, bid = latched id, bresp = SLVERR (10) if the error flag is set, else OKAY (00). On B handshake, go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch the fields and go to R_DATA with the first beat loaded.
  - R_DATA: rvalid=1, rid = latched id, rresp=OKAY, rlast=(counter==len), rdata = registered copy of the addressed word.
  - On R handshake: if not last, load the next beat; if last, go to R_IDLE.
- Narrow transfers (size < log2(DATA_SIZE/8)) rely on the master's wstrb for lane selection. Reads return the full word.
- Simultaneous write and read of the same word on one edge: the read beat loaded on that edge gets the old data, and the write commits.

## Timing
- While areset is high, all outputs are 0 and both FSMs are in IDLE. awready and arready go to 1 on the first aclk edge after areset falls.
- AW handshake at edge N: wready=1 from N+1. W data is never accepted in the same cycle as AW.
- Last W handshake at edge M: bvalid=1 from M+1. The next AW is accepted no earlier than the edge after the B handshake.
- AR handshake at edge N: the first beat is valid from N+1. With rready held high, beats are back to back, so a burst of len+1 beats completes at edge N+len+1.
- Valid outputs (bvalid, rvalid) and their payloads stay stable until the handshake completes.
- areset asserted mid-burst aborts both bursts immediately. Partially written words keep the beats already committed.

## Test plan
- INCR write, awaddr=0x100, size=4, len=3, wdata 0x11..0x14, strobes all 1; then INCR read of the same burst -> bresp=OKAY, rdata 0x11,0x12,0x13,0x14, rlast only on beat 4, rid=arid.
- FIXED write at 0x10, len=3, data 0x11..0x14; then single-beat read of 0x10 -> rdata=0x14.
- Write 0xFFFF..FF to 0x200, then write 0xAB with wstrb=0x0001; then read 0x200 -> rdata=0xFF..FFAB.
- WRAP read at 0x130, size=4, len=3, after words 0x100..0x130 hold 0xA0..0xA3 -> rdata A3, A0, A1, A2.
- Random rready/bready stalls of 1-10 cycles during bursts -> no beat lost or duplicated; payloads held stable while valid is high and ready is low.
- wlast asserted on beat 2 of a len=3 burst -> 4 beats accepted, bresp=SLVERR. areset pulsed mid-read -> rvalid=0 during reset, arready=1 one edge after release.
